cursor_overlay_pipe: RTL
========================

// Module: cursor_overlay_pipe
// PURPOSE
//  Registered, parametrised pointer overlay for the VGA output path. Sits between the
//  background pixel source and the VGA pins; draws a triangular arrow cursor at a
//  scaled game-space position over the incoming pixel stream. Cursor position is
//  snapshotted once per frame, scaled by a multi-cycle divider during blanking, and
//  optionally blinked with a frame-count timer.
// PARAMETERS
//  POS_W        14      width of h_position/v_position (game-space units)
//  POS_DIV      10      game-space units per screen pixel (divisor, >=1)
//  CUR_H        10      arrow height in pixels; arrow width = ceil(CUR_H/2)
//  CUR_COLOR    12'hfff RGB444 cursor colour
//  V_ACTIVE     480     first blanking line; frame boundary = (v_cnt==V_ACTIVE && h_cnt==0)
//  BLINK_FRAMES 30      frames per blink half-period (>=1)
// PORTS
//  clk         in  1      pixel clock
//  rst         in  1      synchronous reset, active high
//  h_position  in  POS_W  cursor x, game-space units
//  v_position  in  POS_W  cursor y, game-space units
//  valid       in  1      active-video flag from VGA timing
//  h_cnt       in  10     current pixel column
//  v_cnt       in  10     current pixel row
//  pixel       in  12     background RGB444 pixel
//  cursor_en   in  1      1 = draw cursor
//  blink_en    in  1      1 = blink cursor
//  vga         out 12     registered RGB444 output
//  cur_x       out 10     applied cursor column (h_position/POS_DIV, truncated to 10b)
//  cur_y       out 10     applied cursor row
//  busy        out 1      divider running
// BEHAVIOUR
//  Reset: vga=0, cur_x=0, cur_y=0, busy=0, FSM=IDLE, frame counter=0, blink phase=ON.
//  Latency: vga at cycle N+1 reflects valid/h_cnt/v_cnt/pixel at cycle N (1 register).
//  Output: !valid -> 0; valid & hit & cursor_en & phase==ON -> CUR_COLOR; else pixel.
//  Hit: dx=h_cnt-cur_x, dy=v_cnt-cur_y evaluated only when h_cnt>=cur_x and v_cnt>=cur_y
//   (no unsigned wrap); hit = dy>=dx && dx+dy<CUR_H. CUR_H=10 -> col0 rows0-9,
//   col1 rows1-8, col2 2-7, col3 3-6, col4 4-5. Cursor near right/bottom edge clips.
//  FSM IDLE -> DIV_H -> DIV_V -> APPLY -> IDLE:
//   IDLE: at frame boundary, snapshot h_position,v_position; busy=1; go DIV_H.
//   DIV_H/DIV_V: restoring divide by POS_DIV, one quotient bit per cycle, POS_W cycles each.
//   APPLY: cur_x/cur_y load truncated quotients together in one cycle; busy=0.
//   Total 2*POS_W+1 cycles after boundary; always completes inside vertical blanking.
//  Position inputs changing mid-frame have no effect until the next frame boundary.
//  Frame boundary while busy: ignored (no restart; snapshot not overwritten).
//  Blink: at each frame boundary with blink_en=1, counter++; at BLINK_FRAMES-1 it wraps
//   to 0 and phase toggles. blink_en=0: counter held 0, phase forced ON.
//  Reset mid-division: division abandoned, cur_x/cur_y return to 0, FSM IDLE.
// TESTING
//  1 rst held 2 cycles -> vga=0, cur_x=cur_y=0, busy=0; release, valid=1, pixel=12'h123 -> vga=12'h123 one cycle later.
//  2 h_pos=1000,v_pos=500, frame boundary -> busy 29 cycles, cur_x=100,cur_y=50; (104,54)&(104,55) -> fff; (104,56),(105,55) -> pixel.
//  3 cur at (0,0): (0,9) -> fff; (639,9) and (0,479) -> pixel (no wrap); cur (638,0): (639,1) -> fff, (0,1) -> pixel.
//  4 change h_position mid-frame -> cur_x unchanged until next boundary; boundary pulsed again while busy -> ignored.
//  5 blink_en=1, BLINK_FRAMES=2 -> cursor visible 2 frames, hidden 2 frames; blink_en=0 -> visible immediately next frame.
//  6 rst asserted at DIV_V cycle 5 -> cur_x=cur_y=0, busy=0 next cycle; next boundary restarts division cleanly.

Source files
------------

// File: rtl/cursor_overlay_pipe.sv
// Pointer overlay for the VGA output path: draws a triangular arrow cursor over
// the background pixel stream. The cursor position is sampled once per frame and
// scaled from game-space units to screen pixels by a bit-serial divider that runs
// during vertical blanking. An optional frame-count timer blinks the cursor.
module cursor_overlay_pipe #(
  parameter int          POS_W        = 14,
  parameter int          POS_DIV      = 10,
  parameter int          CUR_H        = 10,
  parameter logic [11:0] CUR_COLOR    = 12'hfff,
  parameter int          V_ACTIVE     = 480,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] h_position,
  input  logic [POS_W-1:0] v_position,
  input  logic             valid,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  input  logic [11:0]      pixel,
  input  logic             cursor_en,
  input  logic             blink_en,
  output logic [11:0]      vga,
  output logic [9:0]       cur_x,
  output logic [9:0]       cur_y,
  output logic             busy
);

  localparam int CNT_W = (POS_W > 1) ? $clog2(POS_W) : 1;
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [POS_W:0]   DIV_C     = (POS_W + 1)'(POS_DIV);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(POS_W - 1);
  localparam logic [BC_W-1:0]  LAST_FRM  = BC_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV_H, S_DIV_V, S_APPLY} state_t;

  // Arrow shape: column dx spans rows dx .. CUR_H-1-dx below the tip. The
  // subtractions are only formed once the pixel is right of / below the tip,
  // so pixels on the far side of the screen never wrap into a hit.
  function automatic logic arrow_hit(input logic [9:0] hc, input logic [9:0] vc,
                                     input logic [9:0] cx, input logic [9:0] cy);
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [10:0] sum;
    if (hc < cx || vc < cy) return 1'b0;
    dx  = hc - cx;
    dy  = vc - cy;
    sum = {1'b0, dx} + {1'b0, dy};
    return (dy >= dx) && (sum < 11'(CUR_H));
  endfunction

  // Quotient to screen column/row: keep the low 10 bits.
  function automatic logic [9:0] to_pix(input logic [POS_W-1:0] q);
    return 10'(q);
  endfunction

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [POS_W-1:0]   r_work;
  logic [POS_W-1:0]   r_rem;
  logic [POS_W-1:0]   r_vsnap;
  logic [POS_W-1:0]   r_qh;
  logic [9:0]         r_cur_x;
  logic [9:0]         r_cur_y;
  logic [BC_W-1:0]    r_blink_cnt;
  logic               r_phase_on;
  logic [11:0]        r_vga_p1;
  logic               w_frame;
  logic               w_last;
  logic [POS_W:0]     w_rem_sh;
  logic               w_ge;
  logic [POS_W-1:0]   w_rem_nx;
  logic [POS_W-1:0]   w_work_nx;
  logic               w_busy;

  assign w_frame = (v_cnt == 10'(V_ACTIVE)) && (h_cnt == 10'd0);
  assign w_last  = (r_bit_cnt == LAST_BIT);

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits; the quotient bit replaces the dividend bit.
  assign w_rem_sh  = {r_rem, r_work[POS_W-1]};
  assign w_ge      = (w_rem_sh >= DIV_C);
  assign w_rem_nx  = w_ge ? POS_W'(w_rem_sh - DIV_C) : POS_W'(w_rem_sh);
  assign w_work_nx = {r_work[POS_W-2:0], w_ge};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state: boundaries seen while a division is running are ignored
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_frame) w_state_nx = S_DIV_H;
      S_DIV_H: if (w_last)  w_state_nx = S_DIV_V;
      S_DIV_V: if (w_last)  w_state_nx = S_APPLY;
      S_APPLY: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // Divider control: bit counter and applied cursor position
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_bit_cnt <= '0;
        S_DIV_H, S_DIV_V: r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
        S_APPLY: begin
          r_cur_x <= to_pix(r_qh);
          r_cur_y <= to_pix(r_work);
        end
        default: r_bit_cnt <= '0;
      endcase
    end
  end

  // Divider datapath: snapshot, shift/subtract, hand-over from H to V
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (w_frame) begin
          r_work  <= h_position;
          r_vsnap <= v_position;
          r_rem   <= '0;
        end
      end
      S_DIV_H: begin
        if (w_last) begin
          r_qh   <= w_work_nx;
          r_work <= r_vsnap;
          r_rem  <= '0;
        end else begin
          r_work <= w_work_nx;
          r_rem  <= w_rem_nx;
        end
      end
      S_DIV_V: begin
        r_work <= w_work_nx;
        r_rem  <= w_rem_nx;
      end
      default: ;
    endcase
  end

  // Blink timer: advances once per frame while enabled, forced visible otherwise
  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (w_frame) begin
      if (r_blink_cnt == LAST_FRM) begin
        r_blink_cnt <= '0;
        r_phase_on  <= ~r_phase_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Stage p0 -> p1: one-register overlay of the incoming pixel
  always_ff @(posedge clk) begin
    if (rst)
      r_vga_p1 <= '0;
    else if (!valid)
      r_vga_p1 <= '0;
    else if (cursor_en && r_phase_on && arrow_hit(h_cnt, v_cnt, r_cur_x, r_cur_y))
      r_vga_p1 <= CUR_COLOR;
    else
      r_vga_p1 <= pixel;
  end

  assign vga   = r_vga_p1;
  assign cur_x = r_cur_x;
  assign cur_y = r_cur_y;
  assign busy  = w_busy;

endmodule
